store_align_unit: RTL and testbench
===================================

Name: store_align_unit

Overview:
- Write-side counterpart of the load path's sign/zero extension: narrows a 32-bit register value to a byte, halfword or word store and aligns it onto the 4 byte lanes of the data-memory write port with byte strobes.
- Sits between the EX/MEM pipeline register and the data memory.
- Accepts one store per handshake and issues one or two memory beats.
- A store that crosses a word boundary is split into two beats, or faults, depending on a parameter.

Parameters:
- SPLIT_MISALIGNED, 1: 1 = split boundary-crossing stores into two beats; 0 = raise fault instead.
- RESET_ADDR, 32'h0000_0000: reset value of mem_addr and fault_addr.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit can accept a request this cycle.
- req_addr  in  32  byte address of the store.
- req_wdata  in  32  register value; only the low 8/16/32 bits are used.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- mem_valid  out  1  memory beat valid.
- mem_ready  in  1  memory accepts the beat.
- mem_addr  out  32  word-aligned beat address (bits [1:0] = 00).
- mem_wdata  out  32  lane-aligned write data.
- mem_wstrb  out  4  byte enables; bit i enables bits [8i+7:8i].
- fault  out  1  one-cycle pulse: misaligned (when not splitting) or illegal size.
- fault_addr  out  32  req_addr of the faulting request, held until the next fault.

Behaviour:
- Reset: synchronous on a clk edge with rst_n = 0.
  - Outputs: mem_valid = 0, mem_wdata = 0, mem_wstrb = 0, mem_addr = RESET_ADDR, fault = 0, fault_addr = RESET_ADDR.
  - State goes to IDLE. Any in-flight beat, including a pending second beat, is dropped.
  - req_ready = 0 during reset; it is 1 on the first cycle after reset deasserts.
- Lane math on accept, with off = req_addr[1:0]:
  - Narrow value n = req_wdata zero-truncated to the access size.
  - Byte mask m = 1, 3 or F for byte, half or word.
  - 64-bit data D = {32'b0, n} << (8*off). 8-bit strobe S = m << off.
  - Beat 0: addr {req_addr[31:2], 00}, data D[31:0], strobe S[3:0].
  - Beat 1 (exists iff S[7:4] != 0): addr ({req_addr[31:2], 00} + 4) mod 2^32, data D[63:32], strobe S[7:4].
  - 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
- States: IDLE, BEAT0, BEAT1.
  - IDLE: req_ready = 1, mem_valid = 0.
  - Accepting a legal request in IDLE -> BEAT0, with the mem_* outputs registered. Latency is 1 cycle from accept to mem_valid.
  - Beat 1 fields are stored in internal registers at accept.
  - BEAT0, two-beat request: mem_ready -> BEAT1 and load the beat 1 fields. Otherwise hold.
  - BEAT0 with a single beat, or BEAT1: mem_ready completes the request.
- Completion and back-to-back:
  - req_ready = 1 in IDLE, and also in the final beat while mem_ready = 1 (back-to-back).
  - Completion with a same-cycle accept -> BEAT0 with the new request. Without one -> IDLE.
  - Back-to-back single-beat stores sustain 1 store/cycle.
- Stability: while mem_valid = 1 and mem_ready = 0, mem_addr, mem_wdata and mem_wstrb stay stable. mem_valid never drops without a handshake, except on reset.
- Fault:
  - Triggers: req_size = 11, or SPLIT_MISALIGNED = 0 with S[7:4] != 0.
  - On such an accepted request, no memory beat is issued.
  - Next cycle: fault = 1 for one cycle, fault_addr = req_addr, state IDLE.
  - A fault request may be accepted back-to-back in the final-beat cycle; the fault pulse is then issued the next cycle and no beat follows.
- Halfword alignment:
  - A halfword at off = 1 (strobe 0110) is in-word and legal with one beat.
  - A halfword at off = 3 crosses the word boundary.
  - A word at any off != 0 crosses the word boundary.
- Unused strobe lanes carry 0 data (no byte replication).

Decomposition:
- Shared pipeline package holds:
  - Size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - State encoding.
  - A function for the size-to-mask table.
- One natural combinational sub-module, store_lane_shift: (addr[1:0], size, wdata) -> (D[63:0], S[7:0], cross, illegal). It is unit-testable on its own.
- The FSM and output registers stay in the top module.

Test Plan:
- Byte store: addr 0x1003, size 00, wdata 0x123456AB, mem_ready = 1 → next cycle one beat: addr 0x1000, wdata 0xAB000000, wstrb 1000. No fault.
- Split word store: SPLIT = 1, addr 0x1002, size 10, wdata 0xAABBCCDD.
  - Beat 0: 0x1000 / 0xCCDD0000 / 1100.
  - Beat 1: 0x1004 / 0x0000AABB / 0011.
  - req_ready = 0 during beat 0.
- Split halfword store with backpressure: SPLIT = 1, addr 0x2003, half 0x0000BEEF, mem_ready held low 3 cycles.
  - Beat 0: 0x2000 / 0xEF000000 / 1000, held stable for all 3 cycles.
  - Beat 1: 0x2004 / 0x000000BE / 0001.
- Misaligned fault: SPLIT = 0, word at 0x3001 → mem_valid stays 0; fault pulses once; fault_addr = 0x3001.
- Illegal size: size 11 at 0x4000 → fault pulses once; fault_addr = 0x4000.
- Wrap and reset:
  - Split word at 0xFFFFFFFE → beat 1 addr = 0x00000000.
  - Repeat with rst_n = 0 during beat 0 → next cycle mem_valid = 0, state IDLE, beat 1 never issued.
- Back-to-back throughput: 4 aligned words at 0x0, 0x4, 0x8, 0xC with mem_ready = 1 → 4 consecutive beats, strobe 1111 each, no bubbles.

Source files
------------

// File: rtl/store_align_unit_pkg.sv
// Shared definitions for the store alignment path: size encodings,
// FSM state encoding and the size-to-byte-mask table.
package store_align_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_e;

    // Byte-lane mask of an access before shifting by the address offset.
    // The illegal size yields an empty mask so it never enables a lane.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_align_unit_lane_shift.sv
// Combinational lane math: truncates the register value to the access
// size and shifts data and strobes onto an 8-lane (two-word) window.
module store_lane_shift
    import store_align_unit_pkg::*;
(
    input  logic [1:0]  addr_off_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] data_o,
    output logic [7:0]  strb_o,
    output logic        cross_o,
    output logic        illegal_o
);

    logic [31:0] narrow_s;

    // Truncate, then shift into lanes; upper lanes belong to the next word.
    always_comb begin
        narrow_s = 32'd0;
        case (size_i)
            SZ_BYTE: narrow_s = {24'd0, wdata_i[7:0]};
            SZ_HALF: narrow_s = {16'd0, wdata_i[15:0]};
            SZ_WORD: narrow_s = wdata_i;
            default: narrow_s = 32'd0;
        endcase
        data_o    = {32'd0, narrow_s} << {addr_off_i, 3'b000};
        strb_o    = {4'd0, size_mask(size_i)} << addr_off_i;
        cross_o   = |strb_o[7:4];
        illegal_o = (size_i == 2'b11);
    end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: accepts one store per handshake and issues one
// or two word-aligned memory beats, or a one-cycle fault pulse.
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter bit          SPLIT_MISALIGNED = 1'b1,
    parameter logic [31:0] RESET_ADDR       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        fault,
    output logic [31:0] fault_addr
);

    state_e      state_q;
    logic        mem_valid_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic        fault_q;
    logic [31:0] fault_addr_q;
    logic        two_beat_q;
    logic [31:0] b1_addr_q;
    logic [31:0] b1_wdata_q;
    logic [3:0]  b1_wstrb_q;

    logic [63:0] lane_data_s;
    logic [7:0]  lane_strb_s;
    logic        cross_s;
    logic        illegal_s;
    logic        final_beat_s;
    logic        accept_s;
    logic        fault_req_s;
    logic [31:0] base_addr_s;

    store_lane_shift u_lane_shift (
        .addr_off_i (req_addr[1:0]),
        .size_i     (req_size),
        .wdata_i    (req_wdata),
        .data_o     (lane_data_s),
        .strb_o     (lane_strb_s),
        .cross_o    (cross_s),
        .illegal_o  (illegal_s)
    );

    // Handshake decode; a new request may ride on the final beat's handshake.
    always_comb begin
        final_beat_s = ((state_q == ST_BEAT0) && !two_beat_q) || (state_q == ST_BEAT1);
        req_ready    = rst_n && ((state_q == ST_IDLE) || (final_beat_s && mem_ready));
        accept_s     = req_valid && req_ready;
        fault_req_s  = illegal_s || ((SPLIT_MISALIGNED == 1'b0) && cross_s);
        base_addr_s  = {req_addr[31:2], 2'b00};
    end

    // Beat sequencing FSM with registered memory and fault outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= RESET_ADDR;
            mem_wdata_q  <= 32'd0;
            mem_wstrb_q  <= 4'd0;
            fault_q      <= 1'b0;
            fault_addr_q <= RESET_ADDR;
            two_beat_q   <= 1'b0;
            b1_addr_q    <= 32'd0;
            b1_wdata_q   <= 32'd0;
            b1_wstrb_q   <= 4'd0;
        end else begin
            fault_q <= 1'b0;
            if (accept_s) begin
                if (fault_req_s) begin
                    state_q      <= ST_IDLE;
                    mem_valid_q  <= 1'b0;
                    fault_q      <= 1'b1;
                    fault_addr_q <= req_addr;
                end else begin
                    state_q     <= ST_BEAT0;
                    mem_valid_q <= 1'b1;
                    mem_addr_q  <= base_addr_s;
                    mem_wdata_q <= lane_data_s[31:0];
                    mem_wstrb_q <= lane_strb_s[3:0];
                    two_beat_q  <= cross_s;
                    b1_addr_q   <= base_addr_s + 32'd4;
                    b1_wdata_q  <= lane_data_s[63:32];
                    b1_wstrb_q  <= lane_strb_s[7:4];
                end
            end else begin
                case (state_q)
                    ST_BEAT0: begin
                        if (mem_ready) begin
                            if (two_beat_q) begin
                                state_q     <= ST_BEAT1;
                                mem_addr_q  <= b1_addr_q;
                                mem_wdata_q <= b1_wdata_q;
                                mem_wstrb_q <= b1_wstrb_q;
                            end else begin
                                state_q     <= ST_IDLE;
                                mem_valid_q <= 1'b0;
                            end
                        end else begin
                            state_q <= ST_BEAT0;
                        end
                    end
                    ST_BEAT1: begin
                        if (mem_ready) begin
                            state_q     <= ST_IDLE;
                            mem_valid_q <= 1'b0;
                        end else begin
                            state_q <= ST_BEAT1;
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        mem_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench: one splitting instance and one faulting instance
// share the clock, reset, request payload and mem_ready.
module tb_store_align_unit;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        f_valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        mem_ready;

    logic        s_ready, s_mvalid, s_fault;
    logic [31:0] s_maddr, s_mwdata, s_faddr;
    logic [3:0]  s_mwstrb;
    logic        f_ready, f_mvalid, f_fault;
    logic [31:0] f_maddr, f_mwdata, f_faddr;
    logic [3:0]  f_mwstrb;

    int checks = 0;
    int errors = 0;

    store_align_unit #(.SPLIT_MISALIGNED(1'b1), .RESET_ADDR(32'h0000_0000)) dut_s (
        .clk(clk), .rst_n(rst_n), .req_valid(s_valid), .req_ready(s_ready),
        .req_addr(addr), .req_wdata(wdata), .req_size(size),
        .mem_valid(s_mvalid), .mem_ready(mem_ready), .mem_addr(s_maddr),
        .mem_wdata(s_mwdata), .mem_wstrb(s_mwstrb), .fault(s_fault), .fault_addr(s_faddr)
    );

    store_align_unit #(.SPLIT_MISALIGNED(1'b0), .RESET_ADDR(32'h0000_0000)) dut_f (
        .clk(clk), .rst_n(rst_n), .req_valid(f_valid), .req_ready(f_ready),
        .req_addr(addr), .req_wdata(wdata), .req_size(size),
        .mem_valid(f_mvalid), .mem_ready(mem_ready), .mem_addr(f_maddr),
        .mem_wdata(f_mwdata), .mem_wstrb(f_mwstrb), .fault(f_fault), .fault_addr(f_faddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        chk({tag, "_valid"}, {31'd0, s_mvalid}, 32'd1);
        chk({tag, "_addr"}, s_maddr, a);
        chk({tag, "_wdata"}, s_mwdata, d);
        chk({tag, "_wstrb"}, {28'd0, s_mwstrb}, {28'd0, s});
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; f_valid = 1'b0;
        addr = 32'd0; wdata = 32'd0; size = 2'b00; mem_ready = 1'b0;
        step();
        step();
        chk("rst_mvalid", {31'd0, s_mvalid}, 32'd0);
        chk("rst_maddr", s_maddr, 32'h0000_0000);
        chk("rst_mwdata", s_mwdata, 32'd0);
        chk("rst_mwstrb", {28'd0, s_mwstrb}, 32'd0);
        chk("rst_fault", {31'd0, s_fault}, 32'd0);
        chk("rst_faddr", s_faddr, 32'h0000_0000);
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, s_ready}, 32'd1);

        // Byte store at offset 3
        s_valid = 1'b1; addr = 32'h1003; size = 2'b00; wdata = 32'h1234_56AB; mem_ready = 1'b1;
        step();
        s_valid = 1'b0;
        chk_beat("byte", 32'h1000, 32'hAB00_0000, 4'b1000);
        chk("byte_fault", {31'd0, s_fault}, 32'd0);
        step();
        chk("byte_done", {31'd0, s_mvalid}, 32'd0);

        // Split word store
        s_valid = 1'b1; addr = 32'h1002; size = 2'b10; wdata = 32'hAABB_CCDD;
        step();
        s_valid = 1'b0;
        chk_beat("sw_b0", 32'h1000, 32'hCCDD_0000, 4'b1100);
        chk("sw_b0_ready", {31'd0, s_ready}, 32'd0);
        step();
        chk_beat("sw_b1", 32'h1004, 32'h0000_AABB, 4'b0011);
        step();
        chk("sw_done", {31'd0, s_mvalid}, 32'd0);

        // Split halfword with 3 cycles of backpressure
        s_valid = 1'b1; addr = 32'h2003; size = 2'b01; wdata = 32'h0000_BEEF; mem_ready = 1'b0;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_beat("sh_b0_hold", 32'h2000, 32'hEF00_0000, 4'b1000);
            if (i < 2) step();
        end
        mem_ready = 1'b1;
        step();
        chk_beat("sh_b1", 32'h2004, 32'h0000_00BE, 4'b0001);
        step();
        chk("sh_done", {31'd0, s_mvalid}, 32'd0);

        // Misaligned word on the non-splitting instance
        f_valid = 1'b1; addr = 32'h3001; size = 2'b10; wdata = 32'h5555_5555;
        step();
        f_valid = 1'b0;
        chk("mis_mvalid", {31'd0, f_mvalid}, 32'd0);
        chk("mis_fault", {31'd0, f_fault}, 32'd1);
        chk("mis_faddr", f_faddr, 32'h3001);
        step();
        chk("mis_fault_end", {31'd0, f_fault}, 32'd0);
        chk("mis_faddr_held", f_faddr, 32'h3001);
        chk("mis_mvalid2", {31'd0, f_mvalid}, 32'd0);

        // Illegal size
        s_valid = 1'b1; addr = 32'h4000; size = 2'b11; wdata = 32'h1111_1111;
        step();
        s_valid = 1'b0;
        chk("ill_fault", {31'd0, s_fault}, 32'd1);
        chk("ill_faddr", s_faddr, 32'h4000);
        chk("ill_mvalid", {31'd0, s_mvalid}, 32'd0);
        step();
        chk("ill_fault_end", {31'd0, s_fault}, 32'd0);
        chk("ill_mvalid2", {31'd0, s_mvalid}, 32'd0);

        // Split word wrapping past the top of memory
        s_valid = 1'b1; addr = 32'hFFFF_FFFE; size = 2'b10; wdata = 32'h1122_3344;
        step();
        s_valid = 1'b0;
        chk_beat("wrap_b0", 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
        step();
        chk_beat("wrap_b1", 32'h0000_0000, 32'h0000_1122, 4'b0011);
        step();
        chk("wrap_done", {31'd0, s_mvalid}, 32'd0);

        // Same request, reset during beat 0
        s_valid = 1'b1; mem_ready = 1'b0;
        step();
        s_valid = 1'b0;
        chk_beat("rwrap_b0", 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
        rst_n = 1'b0;
        step();
        chk("rwrap_mvalid", {31'd0, s_mvalid}, 32'd0);
        chk("rwrap_maddr", s_maddr, 32'h0000_0000);
        chk("rwrap_ready", {31'd0, s_ready}, 32'd0);
        rst_n = 1'b1; mem_ready = 1'b1;
        #1;
        chk("rwrap_idle_ready", {31'd0, s_ready}, 32'd1);
        step();
        chk("rwrap_no_b1", {31'd0, s_mvalid}, 32'd0);

        // Back-to-back aligned words
        s_valid = 1'b1; size = 2'b10;
        for (int i = 0; i < 4; i++) begin
            addr  = 32'(i * 4);
            wdata = 32'hC0DE_0000 + 32'(i);
            #1;
            chk("b2b_ready", {31'd0, s_ready}, 32'd1);
            step();
            chk_beat("b2b", 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'b1111);
        end
        s_valid = 1'b0;
        step();
        chk("b2b_done", {31'd0, s_mvalid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
